// File: rtl/dmem_if.sv
// Memory-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
interface dmem_if;
    logic        en_dmem;
    logic        load_store;
    logic [2:0]  funct3_dmem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        done;
    logic        stall;
    logic        err;

    modport master (
        output en_dmem, load_store, funct3_dmem, addr, wdata,
        input  rdata, rvalid, done, stall, err
    );

    modport slave (
        input  en_dmem, load_store, funct3_dmem, addr, wdata,
        output rdata, rvalid, done, stall, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word little-endian loads and stores against a
// word RAM, with a fixed number of wait states and a misaligned/illegal error flag.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic            r_ls;
    logic [2:0]      r_f3;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata;

    logic [31:0]     r_rdata;
    logic            r_rvalid;
    logic            r_done;
    logic            r_err;

    logic [31:0]     r_mem [DEPTH];

    logic            w_ls;
    logic [2:0]      w_f3;
    logic [AW+1:0]   w_addr;
    logic [31:0]     w_wdata;
    logic [AW-1:0]   w_widx;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ld_data;
    logic [31:0]     w_st_data;
    logic [3:0]      w_be;
    logic            w_bad;
    logic            w_resp_go;
    logic            w_we;
    logic            w_rvalid_nxt;
    logic            w_unused_addr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.en_dmem) begin
                    w_cnt_nxt   = WAIT_INIT;
                    w_state_nxt = (WAIT_INIT != '0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt <= CW'(1)) w_state_nxt = S_RESP;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, captured on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ls    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == S_IDLE && bus.en_dmem) begin
            r_ls    <= bus.load_store;
            r_f3    <= bus.funct3_dmem;
            r_addr  <= bus.addr[AW+1:0];
            r_wdata <= bus.wdata;
        end
    end

    // With zero wait states RESP is entered straight from IDLE, before the latch is loaded
    always_comb begin
        w_ls    = r_ls;
        w_f3    = r_f3;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_ls    = bus.load_store;
            w_f3    = bus.funct3_dmem;
            w_addr  = bus.addr[AW+1:0];
            w_wdata = bus.wdata;
        end
    end

    // Output / access logic
    always_comb begin
        w_resp_go = (r_state != S_RESP) && (w_state_nxt == S_RESP);

        case (w_f3)
            3'b000:  w_bad = 1'b0;
            3'b100:  w_bad = w_ls;
            3'b001:  w_bad = w_addr[0];
            3'b101:  w_bad = w_ls | w_addr[0];
            3'b010:  w_bad = |w_addr[1:0];
            default: w_bad = 1'b1;
        endcase

        w_widx = w_addr[AW+1:2];
        w_word = r_mem[w_widx];
        w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

        case (w_f3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'h0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'h0, w_half};
            default: w_ld_data = w_word;
        endcase

        case (w_f3)
            3'b000: begin
                w_be      = 4'b0001 << w_addr[1:0];
                w_st_data = {4{w_wdata[7:0]}};
            end
            3'b001: begin
                w_be      = w_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{w_wdata[15:0]}};
            end
            3'b010: begin
                w_be      = 4'b1111;
                w_st_data = w_wdata;
            end
            default: begin
                w_be      = 4'b0000;
                w_st_data = w_wdata;
            end
        endcase

        w_we         = rst_n && w_resp_go && w_ls && !w_bad;
        w_rvalid_nxt = w_resp_go && !w_ls && !w_bad;
    end

    // Response registers; rdata only moves on a legal load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done   <= w_resp_go;
            r_err    <= w_resp_go && w_bad;
            r_rvalid <= w_rvalid_nxt;
            if (w_rvalid_nxt) r_rdata <= w_ld_data;
        end
    end

    // Byte-enabled RAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_st_data[8*i +: 8];
            end
        end
    end

    assign w_unused_addr = ^bus.addr[31:AW+2];

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.stall  = rst_n && ((r_state == S_IDLE && bus.en_dmem) || r_state == S_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with 1, 3 and 0 wait states.
module tb_dmem_responder;
    logic clk;
    logic rst_n;

    logic        en  [3];
    logic        ls  [3];
    logic [2:0]  f3  [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic [31:0] rdt [3];
    logic        rv  [3];
    logic        dn  [3];
    logic        st  [3];
    logic        er  [3];

    int n_cmp = 0;
    int n_bad = 0;

    dmem_if bif0();
    dmem_if bif1();
    dmem_if bif2();

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(bif0.slave));
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst_n(rst_n), .bus(bif1.slave));
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst_n(rst_n), .bus(bif2.slave));

    assign bif0.en_dmem = en[0]; assign bif0.load_store = ls[0]; assign bif0.funct3_dmem = f3[0];
    assign bif0.addr    = ad[0]; assign bif0.wdata      = wd[0];
    assign bif1.en_dmem = en[1]; assign bif1.load_store = ls[1]; assign bif1.funct3_dmem = f3[1];
    assign bif1.addr    = ad[1]; assign bif1.wdata      = wd[1];
    assign bif2.en_dmem = en[2]; assign bif2.load_store = ls[2]; assign bif2.funct3_dmem = f3[2];
    assign bif2.addr    = ad[2]; assign bif2.wdata      = wd[2];

    assign rdt[0] = bif0.rdata; assign rv[0] = bif0.rvalid; assign dn[0] = bif0.done;
    assign st[0]  = bif0.stall; assign er[0] = bif0.err;
    assign rdt[1] = bif1.rdata; assign rv[1] = bif1.rvalid; assign dn[1] = bif1.done;
    assign st[1]  = bif1.stall; assign er[1] = bif1.err;
    assign rdt[2] = bif2.rdata; assign rv[2] = bif2.rvalid; assign dn[2] = bif2.done;
    assign st[2]  = bif2.stall; assign er[2] = bif2.err;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on instance k, presented in the cycle after the call starts
    task automatic req(input int k, input logic s, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rd,
                       input logic exp_rv, input logic exp_err, input string tag);
        int          nst;
        int          lat;
        logic [31:0] rd;
        logic        rvo;
        logic        ero;
        nst = 0; lat = -1; rd = '0; rvo = 1'b0; ero = 1'b0;
        @(posedge clk); #1;
        en[k] = 1'b1; ls[k] = s; f3[k] = f; ad[k] = a; wd[k] = d;
        #1;
        chk({tag, "/done_before"}, 32'(dn[k]), 32'd0);
        if (st[k]) nst++;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (st[k]) nst++;
            if (dn[k]) begin
                lat = n; rd = rdt[k]; rvo = rv[k]; ero = er[k];
                break;
            end
        end
        en[k] = 1'b0;
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/stall_cycles"}, 32'(nst), 32'(exp_lat));
        chk({tag, "/rvalid"}, 32'(rvo), 32'(exp_rv));
        chk({tag, "/err"}, 32'(ero), 32'(exp_err));
        chk({tag, "/rdata"}, rd, exp_rd);
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b1; ls[k] = 1'b0; f3[k] = 3'b010; ad[k] = '0; wd[k] = '0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset%0d/stall", k), 32'(st[k]), 32'd0);
            chk($sformatf("reset%0d/done", k), 32'(dn[k]), 32'd0);
            chk($sformatf("reset%0d/rvalid", k), 32'(rv[k]), 32'd0);
            chk($sformatf("reset%0d/err", k), 32'(er[k]), 32'd0);
            chk($sformatf("reset%0d/rdata", k), rdt[k], 32'd0);
            en[k] = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // One wait state: word, byte and half lanes
        req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0,        1'b0, 1'b0, "sw10");
        req(0, 1'b0, 3'b010, 32'h10, 32'h0,        2, 32'hDEADBEEF, 1'b1, 1'b0, "lw10");
        req(0, 1'b1, 3'b010, 32'h20, 32'h0,        2, 32'hDEADBEEF, 1'b0, 1'b0, "sw20");
        req(0, 1'b1, 3'b000, 32'h23, 32'h12345680, 2, 32'hDEADBEEF, 1'b0, 1'b0, "sb23");
        req(0, 1'b0, 3'b010, 32'h20, 32'h0,        2, 32'h80000000, 1'b1, 1'b0, "lw20");
        req(0, 1'b0, 3'b000, 32'h23, 32'h0,        2, 32'hFFFFFF80, 1'b1, 1'b0, "lb23");
        req(0, 1'b0, 3'b100, 32'h23, 32'h0,        2, 32'h00000080, 1'b1, 1'b0, "lbu23");
        req(0, 1'b1, 3'b010, 32'h30, 32'h11223344, 2, 32'h00000080, 1'b0, 1'b0, "sw30");
        req(0, 1'b1, 3'b001, 32'h32, 32'hABCD8001, 2, 32'h00000080, 1'b0, 1'b0, "sh32");
        req(0, 1'b0, 3'b001, 32'h32, 32'h0,        2, 32'hFFFF8001, 1'b1, 1'b0, "lh32");
        req(0, 1'b0, 3'b101, 32'h32, 32'h0,        2, 32'h00008001, 1'b1, 1'b0, "lhu32");
        req(0, 1'b0, 3'b010, 32'h30, 32'h0,        2, 32'h80013344, 1'b1, 1'b0, "lw30");

        // Misaligned and illegal requests leave RAM and rdata alone
        req(0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 2, 32'h80013344, 1'b0, 1'b0, "sw40");
        req(0, 1'b1, 3'b010, 32'h41, 32'h55555555, 2, 32'h80013344, 1'b0, 1'b1, "sw41_mis");
        req(0, 1'b0, 3'b010, 32'h40, 32'h0,        2, 32'hCAFEF00D, 1'b1, 1'b0, "lw40");
        req(0, 1'b0, 3'b001, 32'h41, 32'h0,        2, 32'hCAFEF00D, 1'b1 & 1'b0, 1'b1, "lh41_mis");
        req(0, 1'b0, 3'b011, 32'h40, 32'h0,        2, 32'hCAFEF00D, 1'b0, 1'b1, "ld_f3_011");
        req(0, 1'b1, 3'b100, 32'h40, 32'h0,        2, 32'hCAFEF00D, 1'b0, 1'b1, "st_f3_100");
        req(0, 1'b0, 3'b000, 32'h40, 32'h0,        2, 32'h0000000D, 1'b1, 1'b0, "lb40");
        req(0, 1'b0, 3'b100, 32'h41, 32'h0,        2, 32'h000000F0, 1'b1, 1'b0, "lbu41");
        req(0, 1'b0, 3'b000, 32'h42, 32'h0,        2, 32'hFFFFFFFE, 1'b1, 1'b0, "lb42");
        req(0, 1'b0, 3'b101, 32'h42, 32'h0,        2, 32'h0000CAFE, 1'b1, 1'b0, "lhu42");

        // Address wrap modulo DEPTH*4
        req(0, 1'b1, 3'b010, 32'h1010, 32'h00000077, 2, 32'h0000CAFE, 1'b0, 1'b0, "sw_wrap");
        req(0, 1'b0, 3'b010, 32'h10,   32'h0,        2, 32'h00000077, 1'b1, 1'b0, "lw_wrap");

        // Zero wait states, back-to-back store then load
        req(2, 1'b1, 3'b010, 32'h60, 32'h0BADF00D, 1, 32'h0,        1'b0, 1'b0, "w0_sw60");
        req(2, 1'b0, 3'b010, 32'h60, 32'h0,        1, 32'h0BADF00D, 1'b1, 1'b0, "w0_lw60");
        req(2, 1'b1, 3'b001, 32'h62, 32'h00001234, 1, 32'h0BADF00D, 1'b0, 1'b0, "w0_sh62");
        req(2, 1'b0, 3'b010, 32'h60, 32'h0,        1, 32'h1234F00D, 1'b1, 1'b0, "w0_lw60b");
        req(2, 1'b0, 3'b010, 32'h61, 32'h0,        1, 32'h1234F00D, 1'b0, 1'b1, "w0_lw61_mis");

        // Three wait states
        req(1, 1'b1, 3'b010, 32'h50, 32'hA5A5A5A5, 4, 32'h0,        1'b0, 1'b0, "w3_sw50");
        req(1, 1'b0, 3'b010, 32'h50, 32'h0,        4, 32'hA5A5A5A5, 1'b1, 1'b0, "w3_lw50");

        // Reset during WAIT abandons the pending store
        @(posedge clk); #1;
        en[1] = 1'b1; ls[1] = 1'b1; f3[1] = 3'b010; ad[1] = 32'h50; wd[1] = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/stall", 32'(st[1]), 32'd0);
        chk("rst_mid/done", 32'(dn[1]), 32'd0);
        chk("rst_mid/rvalid", 32'(rv[1]), 32'd0);
        chk("rst_mid/err", 32'(er[1]), 32'd0);
        chk("rst_mid/rdata", rdt[1], 32'd0);
        en[1] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req(1, 1'b0, 3'b010, 32'h50, 32'h0, 4, 32'hA5A5A5A5, 1'b1, 1'b0, "w3_lw50_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
